// File: rtl/branch_update_unit.sv
// Purpose : queues resolved EX branches and writes pattern/target info into the BTB/PHT tables.
// Latency : conditional 4 cycles pop->write (read, wait, write); jump/return 2 cycles pop->write.
// Backpr. : ex_ready drops while the resolve queue is full; a push is not taken in a full cycle.
//
// Ports:
//   clk, rstn                       clock, async active-low reset
//   ex_vld/ex_ready/ex_pc/ex_taken/
//   ex_target/ex_type               resolved branch from EX (type 00 is dropped)
//   rd_en/rd_addr/rd_slot           pattern table read request
//   rd_vld/rd_past                  read response, valid one cycle after rd_en
//   wr_en/wr_past_en/wr_addr/
//   wr_slot/wr_info/wr_past         table write (info always, pattern when wr_past_en)
//   busy                            FSM active or queue non-empty
module branch_update_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int HASH_DEPTH = 5,
  parameter int PARA_WIDTH = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ex_vld,
  output logic                  ex_ready,
  input  logic [ADDR_WIDTH-1:0] ex_pc,
  input  logic                  ex_taken,
  input  logic [ADDR_WIDTH-1:0] ex_target,
  input  logic [1:0]            ex_type,
  output logic                  rd_en,
  output logic [HASH_DEPTH-1:0] rd_addr,
  output logic                  rd_slot,
  input  logic                  rd_vld,
  input  logic [PARA_WIDTH-1:0] rd_past,
  output logic                  wr_en,
  output logic                  wr_past_en,
  output logic [HASH_DEPTH-1:0] wr_addr,
  output logic                  wr_slot,
  output logic [ADDR_WIDTH-1:0] wr_info,
  output logic [PARA_WIDTH-1:0] wr_past,
  output logic                  busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [HASH_DEPTH-1:0] idx;
    logic                  slot;
    logic                  taken;
    logic [ADDR_WIDTH-3:0] tgt;
    logic [1:0]            typ;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_WRITE} state_t;

  entry_t             q_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   q_cnt;
  logic               push, pop, q_empty;
  entry_t             head, in_entry;
  state_t             state;
  logic               cur_taken;

  // Only the index/slot bits of the PC and the word-aligned target bits are stored.
  logic unused_bits;
  assign unused_bits = ^{ex_pc[ADDR_WIDTH-1:HASH_DEPTH+3], ex_pc[1:0], ex_target[1:0]};

  assign q_empty  = (q_cnt == '0);
  assign ex_ready = (q_cnt != CNT_W'(FIFO_DEPTH));
  // Type 00 carries nothing to learn, so it is silently dropped.
  assign push     = ex_vld && ex_ready && (ex_type != 2'b00);
  assign pop      = (state == S_IDLE) && !q_empty;
  assign head     = q_mem[rd_ptr];
  assign busy     = (state != S_IDLE) || !q_empty;

  assign in_entry.idx   = ex_pc[HASH_DEPTH+2:3];
  assign in_entry.slot  = ex_pc[2];
  assign in_entry.taken = ex_taken;
  assign in_entry.tgt   = ex_target[ADDR_WIDTH-1:2];
  assign in_entry.typ   = ex_type;

  // Saturating update of the counter selected by the stored history; a missing
  // entry is allocated with every counter weakly biased toward the outcome.
  function automatic logic [PARA_WIDTH-1:0] next_past(
    input logic [PARA_WIDTH-1:0] past,
    input logic                  vld,
    input logic                  taken
  );
    logic [PARA_WIDTH-1:0] r;
    logic [1:0]            h;
    logic [1:0]            ctr;
    r   = past;
    h   = past[9:8];
    ctr = past[2*int'(h) +: 2];
    if (!vld) begin
      r = {1'b0, taken, {4{taken ? 2'b10 : 2'b01}}};
    end else begin
      if (taken && ctr != 2'b11)       ctr = ctr + 2'd1;
      else if (!taken && ctr != 2'b00) ctr = ctr - 2'd1;
      r[2*int'(h) +: 2] = ctr;
      r[9:8]            = {h[0], taken};
    end
    return r;
  endfunction

  // Resolve queue pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + 1'b1;
        2'b01:   q_cnt <= q_cnt - 1'b1;
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // Queue storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= in_entry;
  end

  // Update FSM. The next read can only start after the write cycle, so a
  // following update of the same entry always reads the freshly written value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      rd_slot    <= 1'b0;
      wr_en      <= 1'b0;
      wr_past_en <= 1'b0;
      wr_addr    <= '0;
      wr_slot    <= 1'b0;
      wr_info    <= '0;
      wr_past    <= '0;
      cur_taken  <= 1'b0;
    end else begin
      rd_en      <= 1'b0;
      wr_en      <= 1'b0;
      wr_past_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!q_empty) begin
            rd_addr   <= head.idx;
            rd_slot   <= head.slot;
            wr_addr   <= head.idx;
            wr_slot   <= head.slot;
            wr_info   <= {head.tgt, head.typ};
            cur_taken <= head.taken;
            if (head.typ == 2'b01) begin
              rd_en <= 1'b1;
              state <= S_READ;
            end else begin
              wr_en <= 1'b1;
              state <= S_WRITE;
            end
          end
        end
        S_READ: state <= S_WAIT;
        S_WAIT: begin
          wr_past    <= next_past(rd_past, rd_vld, cur_taken);
          wr_past_en <= 1'b1;
          wr_en      <= 1'b1;
          state      <= S_WRITE;
        end
        S_WRITE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_update_unit.sv
module tb_branch_update_unit;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ex_vld = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_pc = '0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic [1:0]  ex_type = '0;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic        rd_slot;
  logic        rd_vld = 1'b0;
  logic [9:0]  rd_past = '0;
  logic        wr_en, wr_past_en, wr_slot, busy;
  logic [4:0]  wr_addr;
  logic [31:0] wr_info;
  logic [9:0]  wr_past;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  branch_update_unit dut (
    .clk(clk), .rstn(rstn),
    .ex_vld(ex_vld), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_type(ex_type),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_slot(rd_slot), .rd_vld(rd_vld), .rd_past(rd_past),
    .wr_en(wr_en), .wr_past_en(wr_past_en), .wr_addr(wr_addr), .wr_slot(wr_slot),
    .wr_info(wr_info), .wr_past(wr_past), .busy(busy)
  );

  // Pattern table model: registered read, write on wr_en&wr_past_en, plus preload/clear ports.
  logic [9:0] mem [32][2];
  logic       mv  [32][2];
  logic       clr_en = 1'b1;
  logic       pre_en = 1'b0;
  logic [4:0] pre_idx = '0;
  logic       pre_slot = 1'b0;
  logic [9:0] pre_val = '0;

  always @(posedge clk) begin
    if (clr_en)
      for (int i = 0; i < 32; i++) begin
        mv[i][0] <= 1'b0;
        mv[i][1] <= 1'b0;
      end
    if (pre_en) begin
      mem[pre_idx][pre_slot] <= pre_val;
      mv[pre_idx][pre_slot]  <= 1'b1;
    end
    if (wr_en && wr_past_en) begin
      mem[wr_addr][wr_slot] <= wr_past;
      mv[wr_addr][wr_slot]  <= 1'b1;
    end
    if (rd_en) begin
      rd_vld  <= mv[rd_addr][rd_slot];
      rd_past <= mem[rd_addr][rd_slot];
    end
  end

  typedef struct packed {
    logic [4:0]  a;
    logic        s;
    logic        pe;
    logic [31:0] info;
    logic [9:0]  past;
  } wr_t;
  wr_t wlog[$];

  always @(negedge clk)
    if (wr_en) wlog.push_back('{wr_addr, wr_slot, wr_past_en, wr_info, wr_past});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [4:0] idx, input logic slot, input logic [9:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_slot = slot; pre_val = val;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                      input logic [1:0] typ);
    int n;
    @(negedge clk);
    ex_pc = pc; ex_taken = tk; ex_target = tgt; ex_type = typ; ex_vld = 1'b1;
    n = 0;
    while (!ex_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ex_ready) chk("push_timeout", 32'(ex_ready), 32'd1);
    @(posedge clk);
    #1 ex_vld = 1'b0;
  endtask

  task automatic wait_wr(input int n);
    int k;
    k = 0;
    while (wlog.size() < n && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("wait_writes", 32'(wlog.size()), 32'(n));
  endtask

  task automatic chk_wr(input int i, input string tag, input logic [4:0] a, input logic s,
                        input logic pe, input logic [31:0] info, input logic [9:0] past);
    wr_t w;
    w = wlog[i];
    chk({tag, "_addr"}, 32'(w.a), 32'(a));
    chk({tag, "_slot"}, 32'(w.s), 32'(s));
    chk({tag, "_past_en"}, 32'(w.pe), 32'(pe));
    chk({tag, "_info"}, w.info, info);
    if (pe) chk({tag, "_past"}, 32'(w.past), 32'(past));
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_past_en", 32'(wr_past_en), 32'd0);
    chk("rst_wr_info", wr_info, 32'd0);
    chk("rst_wr_past", 32'(wr_past), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    clr_en = 1'b0;
    rstn = 1'b1;

    // Cold conditional: allocate
    push(32'h1C, 1'b1, 32'h40, 2'b01);
    wait_wr(1);
    chk_wr(0, "cold", 5'd3, 1'b1, 1'b1, 32'h41, 10'b01_10101010);
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Counter updates on existing entries
    preload(5'd5, 1'b0, 10'b10_11_00_00_00);
    push(32'h28, 1'b0, 32'h100, 2'b01);
    wait_wr(2);
    chk_wr(1, "nt", 5'd5, 1'b0, 1'b1, 32'h101, 10'b00_11_00_00_00);

    preload(5'd6, 1'b1, 10'b10_11_00_00_00);
    push(32'h34, 1'b1, 32'h104, 2'b01);
    wait_wr(3);
    chk_wr(2, "tk", 5'd6, 1'b1, 1'b1, 32'h105, 10'b01_11_01_00_00);

    preload(5'd7, 1'b0, 10'b11_11_10_01_00);
    push(32'h38, 1'b1, 32'h108, 2'b01);
    wait_wr(4);
    chk_wr(3, "sat_hi", 5'd7, 1'b0, 1'b1, 32'h109, 10'b11_11_10_01_00);

    preload(5'd8, 1'b1, 10'b00_11_10_01_00);
    push(32'h44, 1'b0, 32'h10C, 2'b01);
    wait_wr(5);
    chk_wr(4, "sat_lo", 5'd8, 1'b1, 1'b1, 32'h10D, 10'b00_11_10_01_00);

    preload(5'd9, 1'b0, 10'b01_00_00_10_11);
    push(32'h48, 1'b1, 32'h110, 2'b01);
    wait_wr(6);
    chk_wr(5, "mid", 5'd9, 1'b0, 1'b1, 32'h111, 10'b11_00_00_11_11);

    // Fill the queue behind a conditional, then one more push must wait
    push(32'h50, 1'b0, 32'h120, 2'b01);
    push(32'h58, 1'b1, 32'h200, 2'b10);
    push(32'h5C, 1'b1, 32'h204, 2'b10);
    push(32'h60, 1'b0, 32'h208, 2'b11);
    push(32'h64, 1'b1, 32'h20C, 2'b10);
    chk("full_ready", 32'(ex_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    push(32'h68, 1'b0, 32'h210, 2'b10);
    wait_wr(12);
    chk_wr(6, "fill_c", 5'd10, 1'b0, 1'b1, 32'h121, 10'b00_01010101);
    chk_wr(7, "fill_a", 5'd11, 1'b0, 1'b0, 32'h202, 10'd0);
    chk_wr(8, "fill_b", 5'd11, 1'b1, 1'b0, 32'h206, 10'd0);
    chk_wr(9, "fill_c3", 5'd12, 1'b0, 1'b0, 32'h20B, 10'd0);
    chk_wr(10, "fill_d", 5'd12, 1'b1, 1'b0, 32'h20E, 10'd0);
    chk_wr(11, "fill_e", 5'd13, 1'b0, 1'b0, 32'h212, 10'd0);

    // Back-to-back same pc: second read must see the first write
    push(32'h80, 1'b1, 32'h300, 2'b01);
    push(32'h80, 1'b1, 32'h300, 2'b01);
    wait_wr(14);
    chk_wr(12, "b2b1", 5'd16, 1'b0, 1'b1, 32'h301, 10'b01_10101010);
    chk_wr(13, "b2b2", 5'd16, 1'b0, 1'b1, 32'h301, 10'b11_10101110);

    // Type 00 is ignored
    repeat (3) @(negedge clk);
    push(32'h90, 1'b1, 32'h400, 2'b00);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t00_busy", 32'(busy), 32'd0);
    end
    chk("t00_nowrite", 32'(wlog.size()), 32'd14);

    // Reset during WRITE with a second entry still queued
    push(32'hA0, 1'b0, 32'h500, 2'b10);
    push(32'hA4, 1'b0, 32'h504, 2'b10);
    n = 0;
    while (!wr_en && n < 10) begin
      #1;
      n++;
    end
    chk("rst_saw_write", 32'(wr_en), 32'd1);
    rstn = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_ex_ready", 32'(ex_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_past_en", 32'(wr_past_en), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_nowrite", 32'(wlog.size()), 32'd14);
    chk("midrst_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
